// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: money codes, coin values and payout FSM states.
package vm_pkg;

    localparam int unsigned NUM_DENOM = 7;
    localparam int unsigned VAL_W     = 8;

    localparam logic [2:0] MONEY_025  = 3'b000;
    localparam logic [2:0] MONEY_050  = 3'b001;
    localparam logic [2:0] MONEY_1    = 3'b010;
    localparam logic [2:0] MONEY_5    = 3'b011;
    localparam logic [2:0] MONEY_10   = 3'b100;
    localparam logic [2:0] MONEY_20   = 3'b101;
    localparam logic [2:0] MONEY_50   = 3'b110;
    localparam logic [2:0] MONEY_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PICK,
        ST_ISSUE,
        ST_FINISH
    } disp_state_e;

    // Value of a money code in quarter-units; NONE is worth nothing.
    function automatic logic [VAL_W-1:0] money_value(input logic [2:0] code);
        case (code)
            MONEY_025: money_value = 8'd1;
            MONEY_050: money_value = 8'd2;
            MONEY_1:   money_value = 8'd4;
            MONEY_5:   money_value = 8'd20;
            MONEY_10:  money_value = 8'd40;
            MONEY_20:  money_value = 8'd80;
            MONEY_50:  money_value = 8'd200;
            default:   money_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/result, coin-ejector handshake and refill signals of the change dispenser.
interface change_dispenser_if #(
    parameter int unsigned BAL_W = 12
) ();
    logic             req;
    logic [BAL_W-1:0] amt;
    logic             coin_vld;
    logic [2:0]       coin;
    logic             coin_ack;
    logic             refill;
    logic [2:0]       refill_code;
    logic             busy;
    logic             done;
    logic             short;
    logic [BAL_W-1:0] left;

    modport master (
        output req, amt, coin_ack, refill, refill_code,
        input  coin_vld, coin, busy, done, short, left
    );

    modport slave (
        input  req, amt, coin_ack, refill, refill_code,
        output coin_vld, coin, busy, done, short, left
    );
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Per-denomination saturating coin counters with one refill and one payout port.
module coin_inventory
    import vm_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned INIT_CNT = 0
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 refill_i,
    input  logic [2:0]           refill_code_i,
    input  logic                 dec_i,
    input  logic [2:0]           dec_idx_i,
    output logic [NUM_DENOM-1:0] nonzero_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

    logic [CNT_W-1:0]     cnt_q [NUM_DENOM];
    logic [NUM_DENOM-1:0] inc;
    logic [NUM_DENOM-1:0] dec;

    // Per-counter increment/decrement strobes; code NONE selects no counter.
    always_comb begin
        inc       = '0;
        dec       = '0;
        nonzero_o = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            inc[i]       = refill_i && (refill_code_i == 3'(i));
            dec[i]       = dec_i && (dec_idx_i == 3'(i));
            nonzero_o[i] = (cnt_q[i] != '0);
        end
    end

    // Counter update: simultaneous refill and payout on one counter cancel out.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                if (inc[i] && !dec[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy largest-coin-first payout engine driving the coin ejector handshake.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned BAL_W    = 12,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned INIT_CNT = 0
) (
    input  logic              clk,
    input  logic              res_n,
    change_dispenser_if.slave bus
);

    disp_state_e          state_q;
    logic [2:0]           d_q;
    logic [BAL_W-1:0]     rem_q;
    logic [BAL_W-1:0]     left_q;
    logic                 short_q;
    logic [NUM_DENOM-1:0] nonzero;
    logic [BAL_W-1:0]     val_d;
    logic                 can_pay;
    logic                 pay_dec;

    assign val_d   = BAL_W'(money_value(d_q));
    assign can_pay = (val_d <= rem_q) && nonzero[d_q];
    assign pay_dec = (state_q == ST_ISSUE) && bus.coin_ack;

    coin_inventory #(
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_inv (
        .clk           (clk),
        .res_n         (res_n),
        .refill_i      (bus.refill),
        .refill_code_i (bus.refill_code),
        .dec_i         (pay_dec),
        .dec_idx_i     (d_q),
        .nonzero_o     (nonzero)
    );

    // Payout FSM; left/short are loaded on entry to FINISH so they appear with done.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            rem_q   <= '0;
            left_q  <= '0;
            short_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        rem_q   <= bus.amt;
                        d_q     <= 3'(NUM_DENOM - 1);
                        short_q <= 1'b0;
                        state_q <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if ((rem_q == '0) || (!can_pay && (d_q == '0))) begin
                        left_q  <= rem_q;
                        short_q <= (rem_q != '0);
                        state_q <= ST_FINISH;
                    end else if (can_pay) begin
                        state_q <= ST_ISSUE;
                    end else begin
                        d_q <= d_q - 3'd1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.coin_ack) begin
                        rem_q   <= rem_q - val_d;
                        state_q <= ST_PICK;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.coin_vld = (state_q == ST_ISSUE);
    assign bus.coin     = (state_q == ST_ISSUE) ? d_q : MONEY_NONE;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_FINISH);
    assign bus.short    = short_q;
    assign bus.left     = left_q;

endmodule
